tug_playfield: RTL and testbench
================================

# tug_playfield

Playfield controller for the tug-of-war game: turns the two players' raw key inputs into clean single-cycle press pulses and moves a one-hot "rope" light along the LED row, one step per press. It drives the LED row and the press pulses consumed by the winner detector. It freezes the light when the detector reports a winner.

## Interface

Parameters:
- NUM_LEDS, 9: LED count. Odd, ≥ 3. LED index NUM_LEDS is the left end and index 1 is the right end.

Ports:
- Clock, in, 1: single system clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high; clears all state immediately.
- key_L_raw, in, 1: left player key, active-high, asynchronous to Clock.
- key_R_raw, in, 1: right player key, active-high, asynchronous to Clock.
- halt, in, 1: game over (OR of win1/win2 from the detector); freezes the light.
- L, out, 1: one-cycle left-press pulse.
- R, out, 1: one-cycle right-press pulse.
- LEDR, out, NUM_LEDS (indices NUM_LEDS..1): one-hot rope position.
- LED_left, out, 1: equals LEDR[NUM_LEDS]; feeds detector LED9.
- LED_right, out, 1: equals LEDR[1]; feeds detector LED1.

## Operation

- Key path, per key: sync1 <= raw, sync2 <= sync1, prev <= sync2; pulse = sync2 & ~prev. A held key gives exactly one pulse. Repeated presses give one pulse per rising edge of the synchronized key.
- Position register pos is one-hot. CENTER = (NUM_LEDS+1)/2, so position 5 for the default. LEDR = pos.
- Move rules, evaluated each rising edge; the first matching rule applies:
  - halt = 1: hold.
  - L & R in the same cycle: hold, because the presses cancel.
  - L only, pos ≠ NUM_LEDS: shift one step toward NUM_LEDS.
  - R only, pos ≠ 1: shift one step toward 1.
  - L at pos = NUM_LEDS, or R at pos = 1: hold. No wrap. This is the winning press; the detector sees LED_left & L or LED_right & R in this same cycle.
  - Otherwise: hold.
- L and R are always output, including while halt is high. The detector ignores them once latched.
- The light stays frozen until reset. There is no auto-restart.
- Reset values:
  - All sync, prev and edge flops: 0.
  - L = R = 0.
  - pos = one-hot CENTER (LEDR = 9'b000010000 for the default).
  - LED_left = LED_right = 0.
- If a key is held through reset release, one press pulse follows, because prev starts at 0. This is intended.
- Invariant: pos is exactly one-hot in every cycle.

## Timing

- Raw key stable high before edge k: sync2 is high after edge k+1, L/R pulse is high for the single cycle between edges k+1 and k+2, and LEDR moves at edge k+2.
- Press-to-light latency: 2 cycles. Press-to-pulse: 1 cycle plus 0..1 cycle of async sampling uncertainty.
- Pulse width: exactly 1 cycle.
- Minimum key high/low time for guaranteed detection: 2 cycles.
- halt takes effect at the same edge it is sampled high. A pulse coincident with halt rising does not move the light.
- Asynchronous reset asserted mid-press forces the outputs to their reset values immediately. No pulse is generated while reset is high.

## Structure

- Shared package tug_pkg:
  - localparam default NUM_LEDS = 9.
  - CENTER function/constant.
  - Player enum {PLAYER_NONE, PLAYER_LEFT, PLAYER_RIGHT}, for reuse by the winner detector and score blocks.
- Sub-module key_sync: 2-flop synchronizer plus rising-edge detector with async active-high reset. It is instantiated once per key.
- The top level holds the pos register, the move logic and the output assigns.

## Test plan

- Reset: pulse reset mid-cycle with keys low. Required response: LEDR = 000010000 immediately (async), L = R = 0, LED_left = LED_right = 0.
- Single press: hold key_L_raw high for 5 cycles. Required response: exactly one L pulse of 1 cycle, and LEDR becomes 000100000 two edges after the first sampled high.
- March to the end: 4 separate L presses reach LEDR = 100000000 with LED_left = 1. A 5th L press gives an L pulse with LEDR unchanged; the bench's win detector asserts win2. Then with halt = 1, 3 R presses leave LEDR unchanged.
- Simultaneous presses: raise both raw keys on the same cycle from center. Required response: L and R pulse together and LEDR stays 000010000. Then 4 R-only presses give LEDR = 000000001 with no wrap on a 5th press.
- Reset mid-game and held key: at position 3 with key_R_raw held, assert reset for 1 cycle. Required response: LEDR returns to center immediately. After release, exactly one R pulse follows and LEDR = 000001000.

Source files
------------

// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war game blocks.
package tug_pkg;

  localparam int unsigned NUM_LEDS_DEFAULT = 9;

  // Which player an event belongs to; reused by the winner detector and score blocks.
  typedef enum logic [1:0] {
    PLAYER_NONE  = 2'd0,
    PLAYER_LEFT  = 2'd1,
    PLAYER_RIGHT = 2'd2
  } player_e;

  // Middle LED index (1-based) for an odd LED count.
  function automatic int unsigned center_index(input int unsigned num_leds);
    return (num_leds + 1) / 2;
  endfunction

endpackage

// File: rtl/tug_playfield_key_sync.sv
// Two-flop synchronizer for an asynchronous key plus a rising-edge pulse detector.
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // prev clears on reset, so a key held through reset release yields one pulse.
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: key press pulses and the one-hot rope light on the LED row.
module tug_playfield
  import tug_pkg::*;
#(
  parameter int unsigned NUM_LEDS = NUM_LEDS_DEFAULT  // odd, >= 3
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                key_L_raw,
  input  logic                key_R_raw,
  input  logic                halt,
  output logic                L,
  output logic                R,
  output logic [NUM_LEDS:1]   LEDR,
  output logic                LED_left,
  output logic                LED_right
);

  localparam int unsigned CENTER = center_index(NUM_LEDS);
  localparam logic [NUM_LEDS:1] POS_RESET =
    {{(NUM_LEDS - 1){1'b0}}, 1'b1} << (CENTER - 1);

  logic              press_l;
  logic              press_r;
  player_e           mover;
  logic [NUM_LEDS:1] pos;
  logic [NUM_LEDS:1] pos_next;

  key_sync u_key_l (
    .clk   (Clock),
    .rst   (reset),
    .raw   (key_L_raw),
    .pulse (press_l)
  );

  key_sync u_key_r (
    .clk   (Clock),
    .rst   (reset),
    .raw   (key_R_raw),
    .pulse (press_r)
  );

  // Simultaneous presses cancel; halt freezes the light.
  always_comb begin
    mover = PLAYER_NONE;
    if (!halt) begin
      if (press_l && !press_r) begin
        mover = PLAYER_LEFT;
      end else if (press_r && !press_l) begin
        mover = PLAYER_RIGHT;
      end
    end
  end

  // A press at its own end holds (no wrap); that is the winning press.
  always_comb begin
    pos_next = pos;
    case (mover)
      PLAYER_LEFT: begin
        if (!pos[NUM_LEDS]) begin
          pos_next = {pos[NUM_LEDS-1:1], 1'b0};
        end
      end
      PLAYER_RIGHT: begin
        if (!pos[1]) begin
          pos_next = {1'b0, pos[NUM_LEDS:2]};
        end
      end
      default: pos_next = pos;
    endcase
  end

  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      pos <= POS_RESET;
    end else begin
      pos <= pos_next;
    end
  end

  assign L         = press_l;
  assign R         = press_r;
  assign LEDR      = pos;
  assign LED_left  = pos[NUM_LEDS];
  assign LED_right = pos[1];

endmodule

// File: tb/tb_tug_playfield.sv
// Bench for tug_playfield: cycle scoreboard against a behavioural model plus directed end-state checks.
module tb_tug_playfield;

  localparam int unsigned N = 9;
  localparam int unsigned W = N + 4;

  logic         Clock = 1'b0;
  logic         reset;
  logic         key_L_raw;
  logic         key_R_raw;
  logic         halt;
  logic         L;
  logic         R;
  logic [N:1]   LEDR;
  logic         LED_left;
  logic         LED_right;

  tug_playfield #(.NUM_LEDS(N)) dut (
    .Clock     (Clock),
    .reset     (reset),
    .key_L_raw (key_L_raw),
    .key_R_raw (key_R_raw),
    .halt      (halt),
    .L         (L),
    .R         (R),
    .LEDR      (LEDR),
    .LED_left  (LED_left),
    .LED_right (LED_right)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural model: rope position as an integer, key pipelines as bits.
  int   m_pos;
  bit   ls1, ls2, lp, rs1, rs2, rp;
  logic [W-1:0] exp_q[$];

  int lcnt, rcnt, bcnt;
  bit win2;

  function automatic logic [W-1:0] model_vec();
    logic [N:1] oh;
    oh = '0;
    oh[m_pos] = 1'b1;
    return {ls2 & ~lp, rs2 & ~rp, m_pos == N, m_pos == 1, oh};
  endfunction

  task automatic model_reset();
    m_pos = 5;
    {ls1, ls2, lp, rs1, rs2, rp} = '0;
  endtask

  // One clock: advance model at posedge, compare at negedge.
  task automatic tick();
    bit lpu, rpu;
    logic [W-1:0] e;
    @(posedge Clock);
    if (reset) begin
      model_reset();
    end else begin
      lpu = ls2 & ~lp;
      rpu = rs2 & ~rp;
      if (!halt) begin
        if (lpu && !rpu && m_pos != N) m_pos++;
        else if (rpu && !lpu && m_pos != 1) m_pos--;
      end
      lp = ls2; ls2 = ls1; ls1 = key_L_raw;
      rp = rs2; rs2 = rs1; rs1 = key_R_raw;
    end
    exp_q.push_back(model_vec());
    @(negedge Clock);
    e = exp_q.pop_front();
    check("cycle", 32'({L, R, LED_left, LED_right, LEDR}), 32'(e));
    if (L) lcnt++;
    if (R) rcnt++;
    if (L && R) bcnt++;
    if (LED_left && L) win2 = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Mid-cycle async reset: outputs must clear before any clock edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_ledr", 32'(LEDR), 32'(9'b000010000));
    check("rst_lr", 32'({L, R, LED_left, LED_right}), 32'(4'b0000));
    model_reset();
    tick();
    reset = 1'b0;
  endtask

  task automatic press(input bit left, input bit right, input int hold, input int gap);
    key_L_raw = left;
    key_R_raw = right;
    ticks(hold);
    key_L_raw = 1'b0;
    key_R_raw = 1'b0;
    ticks(gap);
  endtask

  initial begin
    reset = 1'b0; key_L_raw = 1'b0; key_R_raw = 1'b0; halt = 1'b0;
    model_reset();
    @(negedge Clock);
    pulse_reset();
    ticks(2);

    // Single held press: one pulse, one step left.
    lcnt = 0;
    press(1, 0, 5, 4);
    check("single_pulses", 32'(lcnt), 32'd1);
    check("single_ledr", 32'(LEDR), 32'(9'b000100000));

    // March to the left end; the extra press is the win.
    for (int i = 0; i < 3; i++) press(1, 0, 2, 3);
    check("march_ledr", 32'(LEDR), 32'(9'b100000000));
    check("march_left", 32'(LED_left), 32'd1);
    win2 = 1'b0; lcnt = 0;
    press(1, 0, 2, 3);
    check("win_pulse", 32'(lcnt), 32'd1);
    check("win_flag", 32'(win2), 32'd1);
    check("win_ledr", 32'(LEDR), 32'(9'b100000000));
    halt = 1'b1;
    rcnt = 0;
    for (int i = 0; i < 3; i++) press(0, 1, 2, 3);
    check("halt_rpulses", 32'(rcnt), 32'd3);
    check("halt_ledr", 32'(LEDR), 32'(9'b100000000));

    // Simultaneous presses cancel.
    halt = 1'b0;
    pulse_reset();
    lcnt = 0; rcnt = 0; bcnt = 0;
    press(1, 1, 3, 3);
    check("both_together", 32'(bcnt), 32'd1);
    check("both_counts", 32'({lcnt[7:0], rcnt[7:0]}), 32'(16'h0101));
    check("both_ledr", 32'(LEDR), 32'(9'b000010000));
    for (int i = 0; i < 4; i++) press(0, 1, 2, 3);
    check("right_end_ledr", 32'(LEDR), 32'(9'b000000001));
    check("right_end_led", 32'(LED_right), 32'd1);
    rcnt = 0;
    press(0, 1, 2, 3);
    check("no_wrap_pulse", 32'(rcnt), 32'd1);
    check("no_wrap_ledr", 32'(LEDR), 32'(9'b000000001));

    // Reset mid-game with the right key held through release.
    pulse_reset();
    for (int i = 0; i < 2; i++) press(0, 1, 2, 3);
    check("pos3_ledr", 32'(LEDR), 32'(9'b000000100));
    key_R_raw = 1'b1;
    tick();
    pulse_reset();
    rcnt = 0;
    ticks(6);
    check("held_pulses", 32'(rcnt), 32'd1);
    check("held_ledr", 32'(LEDR), 32'(9'b000001000));
    key_R_raw = 1'b0;
    ticks(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
